// File: rtl/onehot_to_bin_stream.sv
// onehot_to_bin_stream
//   Encodes a one-hot input beat into a binary index and buffers the result
//   in a 2-entry FIFO with valid/ready handshakes on both sides. Flags beats
//   with no bit set (zero) or several bits set (multi) and counts accepted
//   erroneous beats in a saturating counter.
//
// Parameters
//   ONEHOT_WIDTH  : number of one-hot input bits (>= 2)
//   BIN_WIDTH     : encoded index width
//   PRIO_MODE     : 0 = OR-encode of all set bit indices, 1 = lowest set bit
//   ERR_CNT_WIDTH : error counter width
//
// Ports
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   clear_i   : synchronous clear of the error counter (wins over increment)
//   valid_i   : input beat valid
//   ready_o   : block can accept a beat (registered, independent of ready_i)
//   onehot_i  : one-hot code
//   valid_o   : output beat valid
//   ready_i   : downstream accepts beat
//   bin_o     : encoded index of head entry
//   zero_o    : head beat had no bit set
//   multi_o   : head beat had more than one bit set
//   err_cnt_o : count of accepted zero/multi beats, saturating
module onehot_to_bin_stream #(
    parameter int ONEHOT_WIDTH  = 16,
    parameter int BIN_WIDTH     = $clog2(ONEHOT_WIDTH),
    parameter int PRIO_MODE     = 0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [ONEHOT_WIDTH-1:0]  onehot_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [BIN_WIDTH-1:0]     bin_o,
    output logic                     zero_o,
    output logic                     multi_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    logic [BIN_WIDTH-1:0]     mem_bin   [2];
    logic                     mem_zero  [2];
    logic                     mem_multi [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    logic [BIN_WIDTH-1:0]     enc_bin;
    logic                     enc_zero;
    logic                     enc_multi;
    logic                     push;
    logic                     pop;

    // Encoder: result is computed before storage so the FIFO holds only
    // {bin, zero, multi}.
    always_comb begin
        logic found;
        logic seen_one;
        enc_bin   = '0;
        enc_multi = 1'b0;
        found     = 1'b0;
        seen_one  = 1'b0;
        for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot_i[i]) begin
                if (seen_one) begin
                    enc_multi = 1'b1;
                end
                seen_one = 1'b1;
                if (PRIO_MODE == 0) begin
                    enc_bin = enc_bin | BIN_WIDTH'(i);
                end else if (!found) begin
                    enc_bin = BIN_WIDTH'(i);
                    found   = 1'b1;
                end
            end
        end
        enc_zero = !seen_one;
    end

    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    assign bin_o     = mem_bin[rd_ptr];
    assign zero_o    = mem_zero[rd_ptr];
    assign multi_o   = mem_multi[rd_ptr];
    assign err_cnt_o = err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_bin[0]   <= '0;
            mem_bin[1]   <= '0;
            mem_zero[0]  <= 1'b0;
            mem_zero[1]  <= 1'b0;
            mem_multi[0] <= 1'b0;
            mem_multi[1] <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= '0;
        end else begin
            if (push) begin
                mem_bin[wr_ptr]   <= enc_bin;
                mem_zero[wr_ptr]  <= enc_zero;
                mem_multi[wr_ptr] <= enc_multi;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (clear_i) begin
            err_cnt <= '0;
        end else if (push && (enc_zero || enc_multi) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
module tb_onehot_to_bin_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] onehot = '0;

    logic       rdy0, rdy1, rdy2;
    logic       vo0, vo1, vo2;
    logic [3:0] bin0, bin1, bin2;
    logic       z0, z1, z2;
    logic       m0, m1, m2;
    logic [7:0] err0, err1;
    logic [1:0] err2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: raw accepted input words, oldest first.
    logic [15:0] q[$];
    int          err_big;
    int          err_small;

    always #5 clk = ~clk;

    onehot_to_bin_stream #(.PRIO_MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .ready_o(rdy0),
        .onehot_i(onehot), .valid_o(vo0), .ready_i(ready), .bin_o(bin0),
        .zero_o(z0), .multi_o(m0), .err_cnt_o(err0));

    onehot_to_bin_stream #(.PRIO_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .ready_o(rdy1),
        .onehot_i(onehot), .valid_o(vo1), .ready_i(ready), .bin_o(bin1),
        .zero_o(z1), .multi_o(m1), .err_cnt_o(err1));

    onehot_to_bin_stream #(.PRIO_MODE(0), .ERR_CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .ready_o(rdy2),
        .onehot_i(onehot), .valid_o(vo2), .ready_i(ready), .bin_o(bin2),
        .zero_o(z2), .multi_o(m2), .err_cnt_o(err2));

    function automatic int ref_bin(input logic [15:0] oh, input int mode);
        int r;
        r = 0;
        if (mode == 0) begin
            for (int i = 0; i < 16; i++) if (oh[i]) r = r | i;
        end else begin
            for (int i = 15; i >= 0; i--) if (oh[i]) r = i;
        end
        return r;
    endfunction

    function automatic bit ref_multi(input logic [15:0] oh);
        return $countones(oh) >= 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("valid0", 32'(vo0), 32'(sz > 0));
        chk("valid1", 32'(vo1), 32'(sz > 0));
        chk("valid2", 32'(vo2), 32'(sz > 0));
        chk("ready0", 32'(rdy0), 32'(sz < 2));
        chk("ready1", 32'(rdy1), 32'(sz < 2));
        chk("ready2", 32'(rdy2), 32'(sz < 2));
        chk("err0", 32'(err0), 32'(err_big));
        chk("err1", 32'(err1), 32'(err_big));
        chk("err2", 32'(err2), 32'(err_small));
        if (sz > 0) begin
            chk("bin0", 32'(bin0), 32'(ref_bin(q[0], 0)));
            chk("bin1", 32'(bin1), 32'(ref_bin(q[0], 1)));
            chk("bin2", 32'(bin2), 32'(ref_bin(q[0], 0)));
            chk("zero0", 32'(z0), 32'(q[0] == 16'h0));
            chk("zero1", 32'(z1), 32'(q[0] == 16'h0));
            chk("multi0", 32'(m0), 32'(ref_multi(q[0])));
            chk("multi1", 32'(m1), 32'(ref_multi(q[0])));
            chk("multi2", 32'(m2), 32'(ref_multi(q[0])));
        end else begin
            chk("noX", 32'($isunknown({bin0, bin1, bin2, z0, z1, z2, m0, m1, m2})), 32'd0);
        end
    endtask

    // One clock: reference decides handshakes from its own occupancy,
    // updates after the edge, then outputs are compared.
    task automatic tick();
        bit acc, pop, bad;
        acc = valid && (q.size() < 2) && !rst;
        pop = (q.size() > 0) && ready && !rst;
        bad = (onehot == 16'h0) || ref_multi(onehot);
        @(posedge clk);
        if (!rst) begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(onehot);
            if (clear) begin
                err_big   = 0;
                err_small = 0;
            end else if (acc && bad) begin
                if (err_big < 255) err_big++;
                if (err_small < 3) err_small++;
            end
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        err_big   = 0;
        err_small = 0;
    endtask

    initial begin
        model_reset();
        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", 32'(vo0), 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_err", 32'(err0), 32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Single beat, latency 1
        valid = 1'b1; ready = 1'b1; onehot = 16'h0020;
        tick();
        chk("lat_valid", 32'(vo0), 32'd1);
        chk("lat_bin5", 32'(bin0), 32'd5);
        chk("lat_zero", 32'(z0), 32'd0);
        chk("lat_multi", 32'(m0), 32'd0);
        chk("lat_err", 32'(err0), 32'd0);

        // Two bits set: OR-encode vs lowest-bit priority
        onehot = 16'h0028;
        tick();
        chk("or_bin7", 32'(bin0), 32'd7);
        chk("or_multi", 32'(m0), 32'd1);
        chk("or_err1", 32'(err0), 32'd1);
        chk("prio_bin3", 32'(bin1), 32'd3);
        chk("prio_multi", 32'(m1), 32'd1);
        valid = 1'b0;
        tick();

        // Backpressure: 3 beats offered with ready_i low
        ready = 1'b0; valid = 1'b1;
        onehot = 16'h0002; tick();
        onehot = 16'h0004; tick();
        onehot = 16'h0008; tick();
        chk("bp_ready", 32'(rdy0), 32'd0);
        chk("bp_valid", 32'(vo0), 32'd1);
        chk("bp_bin1", 32'(bin0), 32'd1);
        tick();
        chk("bp_hold", 32'(bin0), 32'd1);
        ready = 1'b1;
        tick();
        chk("bp_out2", 32'(bin0), 32'd2);
        tick();
        chk("bp_out3", 32'(bin0), 32'd3);
        valid = 1'b0;
        tick();
        chk("bp_empty", 32'(vo0), 32'd0);

        // Error counter saturation and clear priority
        valid = 1'b1; onehot = 16'h0000;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_err3", 32'(err2), 32'd3);
        chk("sat_zero", 32'(z2), 32'd1);
        chk("sat_bin0", 32'(bin2), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_err0", 32'(err2), 32'd0);
        chk("clr_err0b", 32'(err0), 32'd0);

        // Fill FIFO, then asynchronous reset mid-cycle
        ready = 1'b0; onehot = 16'h0010;
        tick();
        onehot = 16'h0400;
        tick();
        chk("full_ready", 32'(rdy0), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(vo0), 32'd0);
        chk("arst_ready", 32'(rdy0), 32'd1);
        chk("arst_err", 32'(err2), 32'd0);
        model_reset();
        ready = 1'b1; onehot = 16'h0001;
        tick();
        onehot = 16'h8000;
        rst = 1'b0;
        tick();
        chk("post_bin15", 32'(bin0), 32'd15);
        valid = 1'b0;
        tick();

        // Full-rate burst: a beat in and out every cycle
        valid = 1'b1; ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            onehot = 16'h1 << $urandom_range(15, 0);
            tick();
            chk("burst_ready", 32'(rdy0), 32'd1);
        end

        // Random stream with random backpressure and occasional bad beats
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(3, 0) != 0);
            if ($urandom_range(7, 0) == 0) onehot = 16'($urandom);
            else onehot = 16'h1 << $urandom_range(15, 0);
            ready = ($urandom_range(2, 0) != 0);
            clear = ($urandom_range(31, 0) == 0);
            tick();
        end
        valid = 1'b0; ready = 1'b1; clear = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
